// File: rtl/fpu_issue_arbiter.sv
// fpu_issue_arbiter: shares one pipelined FP add/sub unit between two
// requesters. Round-robin issue, a tag shift register that follows each op
// through the pipeline, and a per-requester response FIFO. Issue is limited
// by credits so a response FIFO can never overflow.
module fpu_issue_arbiter #(
   parameter int ALU_LAT   = 4,
   parameter int RSP_DEPTH = 4
) (
   input  logic        FPUCLK,
   input  logic        FPURSTN,
   input  logic        REQ0_VALID,
   output logic        REQ0_READY,
   input  logic [31:0] REQ0_A,
   input  logic [31:0] REQ0_B,
   input  logic [2:0]  REQ0_CTRL,
   output logic        RSP0_VALID,
   input  logic        RSP0_READY,
   output logic [31:0] RSP0_DATA,
   input  logic        REQ1_VALID,
   output logic        REQ1_READY,
   input  logic [31:0] REQ1_A,
   input  logic [31:0] REQ1_B,
   input  logic [2:0]  REQ1_CTRL,
   output logic        RSP1_VALID,
   input  logic        RSP1_READY,
   output logic [31:0] RSP1_DATA,
   output logic [31:0] ALU_A,
   output logic [31:0] ALU_B,
   output logic [2:0]  ALU_CTRL,
   input  logic [31:0] ALU_OUT,
   output logic        BUSY,
   output logic        ILLEGAL_OP
);

   localparam int PTR_W = $clog2(RSP_DEPTH);
   localparam int CNT_W = $clog2(RSP_DEPTH + 1);
   localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(RSP_DEPTH);
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_NOP = 3'b111;

   logic [CNT_W-1:0] outstanding [2];
   logic [CNT_W-1:0] fifo_count [2];
   logic [PTR_W-1:0] wr_ptr [2];
   logic [PTR_W-1:0] rd_ptr [2];
   logic [31:0]      fifo_mem [2][RSP_DEPTH];

   logic [ALU_LAT-1:0] tag_valid;
   logic [ALU_LAT-1:0] tag_id;

   logic       rr_last;
   logic       illegal_q;
   logic [1:0] req_valid;
   logic [1:0] rsp_ready;
   logic [1:0] pop;
   logic [1:0] push;
   logic [1:0] eligible;
   logic [1:0] grant;
   logic [1:0] issue_vec;
   logic       winner;
   logic       grant_any;
   logic       legal;
   logic       issue;
   logic [2:0] win_ctrl;

   assign req_valid = {REQ1_VALID, REQ0_VALID};
   assign rsp_ready = {RSP1_READY, RSP0_READY};

   // Pops, pushes and credit-based eligibility; a pop in the same cycle frees a credit
   always_comb begin
      pop      = '0;
      push     = '0;
      eligible = '0;
      for (int n = 0; n < 2; n++) begin
         pop[n]      = (fifo_count[n] != '0) && rsp_ready[n];
         eligible[n] = req_valid[n] && ((outstanding[n] < MAX_OUT) || pop[n]);
      end
      if (tag_valid[ALU_LAT-1]) begin
         push = tag_id[ALU_LAT-1] ? 2'b10 : 2'b01;
      end
   end

   // Round-robin pick of the winner and drive of the pipeline inputs
   always_comb begin
      winner    = 1'b0;
      grant_any = |eligible;
      if (eligible[0] && eligible[1]) begin
         winner = ~rr_last;
      end else if (eligible[1]) begin
         winner = 1'b1;
      end
      grant     = grant_any ? (winner ? 2'b10 : 2'b01) : 2'b00;
      win_ctrl  = winner ? REQ1_CTRL : REQ0_CTRL;
      legal     = (win_ctrl == OP_ADD) || (win_ctrl == OP_SUB);
      issue     = grant_any && legal;
      issue_vec = issue ? grant : 2'b00;
      ALU_A     = '0;
      ALU_B     = '0;
      ALU_CTRL  = OP_NOP;
      if (issue) begin
         ALU_A    = winner ? REQ1_A : REQ0_A;
         ALU_B    = winner ? REQ1_B : REQ0_B;
         ALU_CTRL = win_ctrl;
      end
   end

   // Round-robin pointer and sticky illegal-opcode flag
   always_ff @(posedge FPUCLK or negedge FPURSTN) begin
      if (!FPURSTN) begin
         rr_last   <= 1'b1;
         illegal_q <= 1'b0;
      end else begin
         if (grant_any) begin
            rr_last <= winner;
         end
         if (grant_any && !legal) begin
            illegal_q <= 1'b1;
         end
      end
   end

   // Tag shift register that tracks each issued op through the pipeline
   always_ff @(posedge FPUCLK or negedge FPURSTN) begin
      if (!FPURSTN) begin
         tag_valid <= '0;
         tag_id    <= '0;
      end else begin
         tag_valid <= {tag_valid[ALU_LAT-2:0], issue};
         tag_id    <= {tag_id[ALU_LAT-2:0], winner};
      end
   end

   // Outstanding credits and FIFO pointers/occupancy per requester
   always_ff @(posedge FPUCLK or negedge FPURSTN) begin
      if (!FPURSTN) begin
         for (int n = 0; n < 2; n++) begin
            outstanding[n] <= '0;
            fifo_count[n]  <= '0;
            wr_ptr[n]      <= '0;
            rd_ptr[n]      <= '0;
         end
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (issue_vec[n] && !pop[n]) begin
               outstanding[n] <= outstanding[n] + CNT_W'(1);
            end else if (!issue_vec[n] && pop[n]) begin
               outstanding[n] <= outstanding[n] - CNT_W'(1);
            end
            if (push[n] && !pop[n]) begin
               fifo_count[n] <= fifo_count[n] + CNT_W'(1);
            end else if (!push[n] && pop[n]) begin
               fifo_count[n] <= fifo_count[n] - CNT_W'(1);
            end
            if (push[n]) begin
               wr_ptr[n] <= wr_ptr[n] + PTR_W'(1);
            end
            if (pop[n]) begin
               rd_ptr[n] <= rd_ptr[n] + PTR_W'(1);
            end
         end
      end
   end

   // Response storage; contents need no reset since occupancy gates visibility
   always_ff @(posedge FPUCLK) begin
      for (int n = 0; n < 2; n++) begin
         if (push[n]) begin
            fifo_mem[n][wr_ptr[n]] <= ALU_OUT;
         end
      end
   end

   assign REQ0_READY = grant[0];
   assign REQ1_READY = grant[1];
   assign RSP0_VALID = (fifo_count[0] != '0);
   assign RSP1_VALID = (fifo_count[1] != '0);
   assign RSP0_DATA  = fifo_mem[0][rd_ptr[0]];
   assign RSP1_DATA  = fifo_mem[1][rd_ptr[1]];
   assign BUSY       = (|tag_valid) || (fifo_count[0] != '0) || (fifo_count[1] != '0);
   assign ILLEGAL_OP = illegal_q;

endmodule
